// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the parametrised counter
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Number of bits needed to hold values 0..value-1; 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - enabled-cycle divider producing one tick per PRESCALE enabled cycles
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("counter_prescaler: PRESCALE must be >= 1");
  end

  // tick is raw; the owner decides whether a restart overrides it.
  always_comb begin
    cnt_d = cnt_q;
    tick  = en && (cnt_q == LAST);
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - modulo-N up/down counter with prescaler, clear/load and wrap/saturate
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int MODULUS   = 32,
  parameter int SATURATE  = CNT_WRAP,
  parameter int PRESCALE  = 1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("param_updown_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("param_updown_counter: RESET_VAL must be < MODULUS");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             at_bound;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .restart (clear | load),
    .tick    (tick)
  );

  assign at_bound = up ? (q_q == MAX_VAL) : (q_q == '0);

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (clear) begin
      q_d = RST_VAL;
    end else if (load) begin
      q_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (tick) begin
      // tc flags any step attempted at the boundary, including a saturated hold.
      tc_d = at_bound;
      if (at_bound) begin
        if (SATURATE != CNT_SAT) q_d = up ? '0 : MAX_VAL;
      end else begin
        q_d = up ? q_q + 1'b1 : q_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q  <= RST_VAL;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign q    = q_q;
  assign tc   = tc_q;
  assign zero = (q_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - randomized and directed bench against a behavioural counter model
module tb_param_updown_counter;

  localparam int M = 24;
  localparam int R = 3;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, up, clear, load;
  logic [4:0] load_val;
  logic [4:0] dq [N];
  logic       dtc [N];
  logic       dz [N];

  int mq [N];
  int mpre [N];
  int mtc [N];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Instance 0: wrap, no prescale. 1: saturate. 2: wrap, prescale 4.
  param_updown_counter #(.WIDTH(5), .MODULUS(M), .SATURATE(0), .PRESCALE(1), .RESET_VAL(R)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .q(dq[0]), .tc(dtc[0]), .zero(dz[0]));
  param_updown_counter #(.WIDTH(5), .MODULUS(M), .SATURATE(1), .PRESCALE(1), .RESET_VAL(R)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .q(dq[1]), .tc(dtc[1]), .zero(dz[1]));
  param_updown_counter #(.WIDTH(5), .MODULUS(M), .SATURATE(0), .PRESCALE(4), .RESET_VAL(R)) u_pre (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .q(dq[2]), .tc(dtc[2]), .zero(dz[2]));

  function automatic int ps_of(int i);
    return (i == 2) ? 4 : 1;
  endfunction

  function automatic bit sat_of(int i);
    return (i == 1);
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i] = R;
      mpre[i] = 0;
      mtc[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      mtc[i] = 0;
      if (clear) begin
        mq[i] = R;
        mpre[i] = 0;
      end else if (load) begin
        mq[i] = (int'(load_val) > M - 1) ? M - 1 : int'(load_val);
        mpre[i] = 0;
      end else if (en) begin
        mpre[i] = mpre[i] + 1;
        if (mpre[i] == ps_of(i)) begin
          mpre[i] = 0;
          if (up) begin
            mtc[i] = (mq[i] == M - 1);
            if (mq[i] != M - 1) mq[i] = mq[i] + 1;
            else if (!sat_of(i)) mq[i] = 0;
          end else begin
            mtc[i] = (mq[i] == 0);
            if (mq[i] != 0) mq[i] = mq[i] - 1;
            else if (!sat_of(i)) mq[i] = M - 1;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("%s_q%0d", tag, i), int'(dq[i]), mq[i]);
      check_eq($sformatf("%s_tc%0d", tag, i), int'(dtc[i]), mtc[i]);
      check_eq($sformatf("%s_zero%0d", tag, i), int'(dz[i]), int'(mq[i] == 0));
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Called just after a cycle check; pulses reset well away from any edge.
  task automatic async_reset(input string tag);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 reset = 1'b0;
  endtask

  task automatic set_in(input logic e, input logic u, input logic c, input logic l, input int lv);
    en = e;
    up = u;
    clear = c;
    load = l;
    load_val = 5'(lv);
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 1, 0, 0, 0);
    model_reset();
    #1;
    check_all("reset");
    #3 reset = 1'b0;

    repeat (3) cycle("hold");
    async_reset("rst_pulse");
    repeat (2) cycle("hold2");

    set_in(0, 1, 0, 1, 0);
    cycle("ld0");
    set_in(1, 1, 0, 0, 0);
    repeat (24) cycle("wrap_up");
    check_eq("wrap_q_direct", int'(dq[0]), 0);
    check_eq("wrap_tc_direct", int'(dtc[0]), 1);
    repeat (3) cycle("wrap_up2");

    set_in(0, 1, 0, 1, 0);
    cycle("ld0b");
    set_in(1, 0, 0, 0, 0);
    cycle("down");
    check_eq("down_q_direct", int'(dq[0]), 23);
    check_eq("down_tc_direct", int'(dtc[0]), 1);
    check_eq("sat_down_q_direct", int'(dq[1]), 0);
    repeat (3) cycle("down2");

    set_in(0, 1, 0, 1, 23);
    cycle("ld23");
    set_in(1, 1, 0, 0, 0);
    repeat (4) cycle("sat_up");
    check_eq("sat_q_direct", int'(dq[1]), 23);
    check_eq("sat_tc_direct", int'(dtc[1]), 1);

    set_in(1, 1, 1, 1, 10);
    cycle("clr_ld");
    check_eq("clr_prio_direct", int'(dq[0]), R);
    set_in(1, 1, 0, 1, 30);
    cycle("clamp");
    check_eq("clamp_q_direct", int'(dq[0]), 23);
    check_eq("clamp_tc_direct", int'(dtc[0]), 0);

    set_in(0, 1, 0, 1, 5);
    cycle("ld5");
    set_in(1, 1, 0, 0, 0);
    repeat (3) cycle("pre_wait");
    check_eq("pre_hold_direct", int'(dq[2]), 5);
    cycle("pre_step");
    check_eq("pre_step_direct", int'(dq[2]), 6);
    repeat (2) cycle("pre_en");
    set_in(0, 1, 0, 0, 0);
    repeat (2) cycle("pre_gap");
    set_in(1, 1, 0, 0, 0);
    cycle("pre_resume");
    check_eq("pre_delay_direct", int'(dq[2]), 6);
    cycle("pre_step2");
    check_eq("pre_step2_direct", int'(dq[2]), 7);

    set_in(0, 1, 0, 1, 16);
    cycle("ld16");
    set_in(1, 1, 0, 0, 0);
    cycle("to17");
    check_eq("mid_q_direct", int'(dq[0]), 17);
    async_reset("mid_rst");
    check_eq("mid_rst_q_direct", int'(dq[0]), R);
    repeat (5) cycle("post_rst");

    repeat (400) begin
      set_in(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 31) == 0),
             ($urandom_range(0, 15) == 0), int'($urandom_range(0, 31)));
      cycle("rand");
      if ($urandom_range(0, 63) == 0) async_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
